// File: rtl/div_iter.sv
// Multi-cycle 32-bit restoring divider for MIPS div/divu.
// Returns {remainder, quotient}; ready_o stays high until start_i drops.
module div_iter (
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BYZERO = 2'd1,
    ON     = 2'd2,
    END    = 2'd3
  } state_t;

  state_t state, next_state;

  logic [CW-1:0]   cnt;
  logic [2*DW-1:0] w;
  logic [DW-1:0]   dvs;
  logic            neg_q;
  logic            neg_r;

  logic [DW-1:0]   abs1, abs2;
  logic [2*DW:0]   shifted;
  logic [DW:0]     trial;
  logic [2*DW-1:0] w_step;
  logic [DW-1:0]   quo, rem;
  logic [2*DW-1:0] fixed;

  // Operand magnitudes; only signed mode treats bit 31 as a sign.
  always_comb begin
    abs1 = (signed_div_i && opdata1_i[DW-1]) ? (~opdata1_i + DW'(1)) : opdata1_i;
    abs2 = (signed_div_i && opdata2_i[DW-1]) ? (~opdata2_i + DW'(1)) : opdata2_i;
  end

  // One shift-subtract step; the top bit of trial is set when the subtraction borrows.
  always_comb begin
    shifted = {w, 1'b0};
    trial   = shifted[2*DW:DW] - {1'b0, dvs};
    w_step  = trial[DW] ? shifted[2*DW-1:0] : {trial[DW-1:0], shifted[DW-1:1], 1'b1};
    quo     = w_step[DW-1:0];
    rem     = w_step[2*DW-1:DW];
    fixed   = {(neg_r ? (~rem + DW'(1)) : rem), (neg_q ? (~quo + DW'(1)) : quo)};
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start_i && !annul_i) begin
          next_state = (opdata2_i == '0) ? BYZERO : ON;
        end
      end
      BYZERO: next_state = END;
      ON: begin
        if (annul_i)                 next_state = IDLE;
        else if (cnt == CW'(DW - 1)) next_state = END;
      end
      END: begin
        if (!start_i) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Datapath and registered outputs; the signed fix-up is applied on entry to END.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      w        <= '0;
      dvs      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      result_o <= '0;
      ready_o  <= 1'b0;
    end else begin
      if (state == IDLE && next_state == ON) begin
        w     <= {DW'(0), abs1};
        dvs   <= abs2;
        neg_q <= signed_div_i && (opdata1_i[DW-1] ^ opdata2_i[DW-1]);
        neg_r <= signed_div_i && opdata1_i[DW-1];
        cnt   <= '0;
      end else if (state == ON && !annul_i) begin
        w   <= w_step;
        cnt <= cnt + CW'(1);
      end

      ready_o <= (next_state == END);
      if (next_state == END) begin
        if (state == ON)          result_o <= fixed;
        else if (state == BYZERO) result_o <= '0;
      end else begin
        result_o <= '0;
      end
    end
  end

endmodule

// File: tb/tb_div_iter.sv
// Self-checking bench for div_iter: directed corner cases plus random divisions
// compared against an arithmetic reference model.
module tb_div_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  div_iter dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  // Reference: plain 64-bit integer division (truncating, remainder follows dividend).
  function automatic logic [63:0] model(input bit sd, input logic [31:0] a, input logic [31:0] b);
    longint q, r, sa, sb;
    if (b == 32'd0) return 64'd0;
    if (sd) begin
      sa = longint'(signed'(a));
      sb = longint'(signed'(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Launch one division, scramble the inputs while it runs, check latency/result/hold/exit.
  task automatic run_div(input bit sd, input logic [31:0] a, input logic [31:0] b,
                         input int hold, input string tag);
    logic [63:0] exp;
    int cyc;
    int lat;
    exp = model(sd, a, b);
    lat = (b == 32'd0) ? 2 : 33;
    @(negedge clk);
    signed_div_i = sd;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      opdata1_i    = $urandom;
      opdata2_i    = $urandom;
      signed_div_i = 1'($urandom);
    end while (!ready_o && cyc < 40);
    check($sformatf("%s_latency", tag), 64'(cyc), 64'(lat));
    check($sformatf("%s_result", tag), result_o, exp);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check($sformatf("%s_hold_ready", tag), 64'(ready_o), 64'd1);
      check($sformatf("%s_hold_result", tag), result_o, exp);
    end
    start_i = 1'b0;
    @(negedge clk);
    check($sformatf("%s_exit_ready", tag), 64'(ready_o), 64'd0);
    check($sformatf("%s_exit_result", tag), result_o, 64'd0);
  endtask

  initial begin
    bit          sd;
    logic [31:0] a, b;
    int          seen;

    rst = 1'b1; signed_div_i = 1'b0; opdata1_i = '0; opdata2_i = '0;
    start_i = 1'b0; annul_i = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_ready", 64'(ready_o), 64'd0);
    check("reset_result", result_o, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_ready", 64'(ready_o), 64'd0);

    // Directed cases
    run_div(1'b0, 32'd100, 32'd7, 0, "u100_7");
    run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 0, "s_m7_2");
    run_div(1'b1, 32'd7, 32'hFFFF_FFFE, 0, "s_7_m2");
    run_div(1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 0, "s_m7_m2");
    run_div(1'b1, 32'd7, 32'd2, 0, "s_7_2");
    run_div(1'b0, 32'hFFFF_FFF9, 32'd2, 0, "u_big_2");
    run_div(1'b0, 32'd1234, 32'd0, 0, "u_div0");
    run_div(1'b1, 32'hFFFF_FF00, 32'd0, 0, "s_div0");
    run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, "s_intmin_m1");
    run_div(1'b0, 32'hDEAD_BEEF, 32'h0000_1235, 5, "u_hold5");
    run_div(1'b0, 32'd5, 32'hFFFF_FFFF, 0, "u_small_big");

    // Annul during ON at T+10, then a fresh division
    @(negedge clk);
    signed_div_i = 1'b0; opdata1_i = 32'd999; opdata2_i = 32'd3; start_i = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ready_o) seen++;
    end
    annul_i = 1'b1;
    @(negedge clk);
    check("annul_ready_t11", 64'(ready_o), 64'd0);
    check("annul_result_t11", result_o, 64'd0);
    annul_i = 1'b0; start_i = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (ready_o) seen++;
    end
    check("annul_never_ready", 64'(seen), 64'd0);
    run_div(1'b1, 32'hFFFF_FC19, 32'd3, 0, "after_annul");

    // Annul and start together in IDLE must not launch
    @(negedge clk);
    opdata1_i = 32'd50; opdata2_i = 32'd5; start_i = 1'b1; annul_i = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ready_o) seen++;
    end
    check("idle_annul_start", 64'(seen), 64'd0);
    start_i = 1'b0; annul_i = 1'b0;

    // Reset mid-operation at T+20
    @(negedge clk);
    signed_div_i = 1'b0; opdata1_i = 32'd77777; opdata2_i = 32'd13; start_i = 1'b1;
    repeat (20) @(negedge clk);
    rst = 1'b1; start_i = 1'b0;
    @(negedge clk);
    check("midrst_ready", 64'(ready_o), 64'd0);
    check("midrst_result", result_o, 64'd0);
    rst = 1'b0;
    run_div(1'b0, 32'd77777, 32'd13, 0, "after_rst");

    // Random divisions
    for (int n = 0; n < 24; n++) begin
      sd = 1'($urandom);
      a  = $urandom;
      case ($urandom_range(0, 4))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = 32'hFFFF_FFFF - 32'($urandom_range(0, 7));
        default: b = $urandom;
      endcase
      run_div(sd, a, b, int'($urandom_range(0, 2)), $sformatf("rand%0d", n));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/div_iter.md
# div_iter

Multi-cycle 32-bit integer divider that sits beside the single-cycle ALU in the EX stage and executes MIPS `div` and `divu`. It takes a start request from EX and runs a 32-iteration restoring shift-subtract loop. It returns quotient and remainder for the HI/LO registers, and EX stalls the pipeline until `ready_o` is high. The ALU covers multiplication-side and logic ops combinationally; this block provides the inverse operation sequentially.

## Interface
Parameters:
- none; width is fixed at 32 bits for operands and 64 bits for the result.

Ports:
- clk  in  1  clock; every register updates on the rising edge.
- rst  in  1  reset; synchronous and active-high.
- signed_div_i  in  1  1 selects signed (`div`), 0 selects unsigned (`divu`).
- opdata1_i  in  32  dividend.
- opdata2_i  in  32  divisor.
- start_i  in  1  request; EX holds it high for the whole stall.
- annul_i  in  1  abort the current division (exception or flush).
- result_o  out  64  {remainder[63:32], quotient[31:0]}.
- ready_o  out  1  result valid.

## Operation
- States are IDLE, BYZERO, ON and END. Reset forces IDLE, with `result_o` = 0 and `ready_o` = 0.
- IDLE, `start_i`=1, `annul_i`=0:
  - Divisor = 0 goes to BYZERO.
  - Otherwise latch the operands and the sign flags, clear the counter, and go to ON.
  - In signed mode, negative operands are replaced by their two's-complement magnitude.
- IDLE otherwise: stay in IDLE; outputs are 0.
- BYZERO: load result 0 and go to END unconditionally.
- ON, one iteration per cycle, using a 65-bit working register W:
  - W initialises to {33'b0, |dividend|}.
  - Each iteration: shift W left 1, then trial = W[64:32] − {1'b0, |divisor|}.
  - If trial is non-negative, W[64:32] = trial and W[0] = 1.
  - Counter increments 0..31; after iteration 31 go to END.
- ON with `annul_i`=1 (any iteration): go to IDLE next cycle, discard the partial result, and never raise `ready_o`.
- ON with `start_i` dropped while `annul_i`=0 is illegal; the block continues regardless.
- END:
  - `ready_o`=1 and `result_o` holds the final value.
  - Signed fix-up is registered on entry to END: quotient is negated if the operand signs differ; remainder takes the sign of the dividend.
  - Stay in END while `start_i`=1; go to IDLE on the cycle `start_i`=0.
  - `annul_i` in END is ignored.
- Signed INT_MIN / −1 gives quotient 0x80000000, remainder 0 (natural wrap, no trap).
- Operands are sampled only on the IDLE→ON transition; input changes during ON have no effect.

## Timing
- `start_i` sampled in IDLE at edge T:
  - Normal divide: ON occupies cycles T+1..T+32; END and `ready_o`=1 from T+33.
  - Divide by zero: BYZERO at T+1; END and `ready_o`=1 at T+2.
- `ready_o` and `result_o` are registered; there is no combinational path from inputs to outputs.
- `ready_o` stays high for every cycle in END, at least one cycle.
- The cycle after `start_i` falls in END: IDLE, with `ready_o`=0 and `result_o`=0.
- A new `start_i` is accepted no earlier than the cycle after returning to IDLE.
- `rst`=1 mid-operation: IDLE on the next edge, outputs 0, counter cleared. `rst` has priority over `annul_i` and `start_i`.
- `annul_i` and `start_i` high together in IDLE: stay in IDLE.

## Test plan
- Unsigned 100 / 7, start at T → `ready_o` rises at T+33, `result_o` = {0x00000002, 0x0000000E}; drop start → `ready_o`=0 at the next cycle.
- Signed −7 / 2 → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Also cover the other three sign combinations (7/−2 → −3 r 1; −7/−2 → 3 r −1), plus unsigned 0xFFFFFFF9 / 2 → 0x7FFFFFFC r 1.
- Divisor 0 (signed and unsigned) → `ready_o` at T+2, `result_o` = 0. Signed 0x80000000 / 0xFFFFFFFF → {0, 0x80000000}.
- Annul at T+10 → IDLE at T+11 and `ready_o` never asserts. A fresh start at T+12 completes correctly at T+45.
- Hold `start_i` for 5 extra cycles in END → `ready_o` and `result_o` stable throughout; operand changes during ON do not alter the result.
- Assert `rst` at T+20 → IDLE with zero outputs at T+21; a following division completes with the correct value.
